// File: rtl/i_fetch_ctrl.sv
// Instruction fetch controller: drives the ROM word address, queues fetched
// words with their PCs in a prefetch FIFO, and handles redirects and range faults.
module i_fetch_ctrl #(
    parameter int unsigned ROM_SIZE   = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          fetch_en,
    output logic [31:0]                   imem_addr,
    input  logic [31:0]                   imem_data,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst_data,
    output logic [31:0]                   inst_pc,
    output logic                          inst_fault,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_e;

    state_e             state_q;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [31:0]        data_mem  [FIFO_DEPTH];
    logic [31:0]        pc_mem    [FIFO_DEPTH];
    logic               fault_mem [FIFO_DEPTH];

    logic               pop;
    logic               push;
    logic               fetch_fault;
    logic               unused_rpc_bits;

    // The low two redirect bits are architecturally ignored.
    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign imem_addr   = {2'b00, fetch_pc_q[31:2]};
    assign fetch_fault = imem_addr >= ROM_SIZE;

    assign inst_valid  = (count_q != '0);
    assign pop         = inst_valid && inst_ready;
    assign push        = reset_n && !redirect_valid && (state_q == RUN) && fetch_en
                         && ((count_q != FULL_CNT) || pop);

    assign inst_data   = inst_valid ? data_mem[rd_ptr_q]  : 32'h0;
    assign inst_pc     = inst_valid ? pc_mem[rd_ptr_q]    : 32'h0;
    assign inst_fault  = inst_valid && fault_mem[rd_ptr_q];
    assign fifo_count  = count_q;

    // NOTE: combinational next-state uses blocking '=' with a default for every
    // target first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (!fetch_fault) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (redirect_valid) begin
                if (state_q == HALTED) begin
                    state_q <= fetch_en ? RUN : IDLE;
                end
            end else begin
                unique case (state_q)
                    IDLE:    if (fetch_en) state_q <= RUN;
                    RUN: begin
                        if (!fetch_en) begin
                            state_q <= IDLE;
                        end else if (push && fetch_fault) begin
                            state_q <= HALTED;
                        end
                    end
                    HALTED:  state_q <= HALTED;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // NOTE: the FIFO storage has no reset; validity is carried entirely by
    // count_q, and empty-state outputs are forced to zero above.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_q]  <= fetch_fault ? 32'h0 : imem_data;
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            fault_mem[wr_ptr_q] <= fetch_fault;
        end
    end

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// Self-checking bench for i_fetch_ctrl: directed scenarios plus randomized
// stimulus compared against a queue-based reference model.
module tb_i_fetch_ctrl;

    localparam int unsigned ROM_SIZE   = 64;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam logic [31:0] ROM_BASE   = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // ROM word k holds ROM_BASE + k; out-of-range reads return junk on purpose.
    assign imem_data = ROM_BASE + imem_addr;

    i_fetch_ctrl #(
        .ROM_SIZE   (ROM_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .fifo_count     (fifo_count)
    );

    // Reference model: a queue of delivered-to-decode entries plus the next PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } entry_t;

    typedef enum {M_IDLE, M_RUN, M_HALT} mode_e;

    entry_t      mq[$];
    logic [31:0] m_pc;
    mode_e       m_mode;

    function automatic void model_step(bit rst_n, bit en, bit redir, logic [31:0] rpc, bit rdy);
        bit          take;
        bit          room;
        logic [31:0] wa;
        entry_t      e;
        if (!rst_n) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_mode = M_IDLE;
            return;
        end
        take = (mq.size() != 0) && rdy;
        if (redir) begin
            mq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            if (m_mode == M_HALT) m_mode = en ? M_RUN : M_IDLE;
            return;
        end
        room = (mq.size() < FIFO_DEPTH) || take;
        if (take) void'(mq.pop_front());
        case (m_mode)
            M_IDLE: if (en) m_mode = M_RUN;
            M_RUN: begin
                if (!en) begin
                    m_mode = M_IDLE;
                end else if (room) begin
                    wa = m_pc / 4;
                    e.pc = m_pc;
                    if (wa >= ROM_SIZE) begin
                        e.data  = 32'h0;
                        e.fault = 1'b1;
                        m_mode  = M_HALT;
                    end else begin
                        e.data  = ROM_BASE + wa;
                        e.fault = 1'b0;
                        m_pc    = m_pc + 32'd4;
                    end
                    mq.push_back(e);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step(reset_n, fetch_en, redirect_valid, redirect_pc, inst_ready);
        #1;
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (inst_valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %b expected 0", inst_valid); end
        checks++; if (inst_data !== 32'h0)     begin errors++; $display("FAIL reset_data got %h expected 0", inst_data); end
        checks++; if (inst_pc !== 32'h0)       begin errors++; $display("FAIL reset_pc got %h expected 0", inst_pc); end
        checks++; if (inst_fault !== 1'b0)     begin errors++; $display("FAIL reset_fault got %b expected 0", inst_fault); end
        checks++; if (fifo_count !== 3'd0)     begin errors++; $display("FAIL reset_count got %0d expected 0", fifo_count); end
        checks++; if (imem_addr !== (RESET_PC >> 2)) begin errors++; $display("FAIL reset_imem_addr got %h expected %h", imem_addr, RESET_PC >> 2); end
    endtask

    task automatic test_startup_stream();
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL start_e1_valid got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1)          begin errors++; $display("FAIL start_e2_valid got %b expected 1", inst_valid); end
        checks++; if (inst_pc !== 32'h0)            begin errors++; $display("FAIL start_e2_pc got %h expected 0", inst_pc); end
        checks++; if (inst_data !== 32'h1000_0000)  begin errors++; $display("FAIL start_e2_data got %h expected 10000000", inst_data); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if (inst_pc !== 32'(4 * i))          begin errors++; $display("FAIL stream_pc[%0d] got %h expected %h", i, inst_pc, 4 * i); end
            checks++; if (inst_data !== ROM_BASE + 32'(i)) begin errors++; $display("FAIL stream_data[%0d] got %h expected %h", i, inst_data, ROM_BASE + 32'(i)); end
            checks++; if (fifo_count !== 3'd1)             begin errors++; $display("FAIL stream_count[%0d] got %0d expected 1", i, fifo_count); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        apply_reset();
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        tick();
        repeat (10) tick();
        checks++; if (fifo_count !== 3'd4)  begin errors++; $display("FAIL bp_count got %0d expected 4", fifo_count); end
        checks++; if (imem_addr !== 32'd4)  begin errors++; $display("FAIL bp_imem_addr got %h expected 4", imem_addr); end
        checks++; if (inst_pc !== 32'h0)    begin errors++; $display("FAIL bp_head_pc got %h expected 0", inst_pc); end
        inst_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin
                errors++;
                $display("FAIL bp_drain_pc[%0d] got valid=%b pc=%h expected valid=1 pc=%h", i, inst_valid, inst_pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            tick();
        end
    endtask

    task automatic test_redirect();
        inst_ready = 1'b0;
        repeat (6) tick();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0013;
        tick();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0)  begin errors++; $display("FAIL redir_valid got %b expected 0", inst_valid); end
        checks++; if (fifo_count !== 3'd0)  begin errors++; $display("FAIL redir_count got %0d expected 0", fifo_count); end
        checks++; if (imem_addr !== 32'd4)  begin errors++; $display("FAIL redir_imem_addr got %h expected 4", imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1)          begin errors++; $display("FAIL redir_next_valid got %b expected 1", inst_valid); end
        checks++; if (inst_pc !== 32'h0000_0010)    begin errors++; $display("FAIL redir_next_pc got %h expected 10", inst_pc); end
        checks++; if (inst_data !== 32'h1000_0004)  begin errors++; $display("FAIL redir_next_data got %h expected 10000004", inst_data); end
    endtask

    task automatic test_fault();
        logic [31:0] exp_pc;
        inst_ready     = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd240;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_pc = 32'd240 + 32'(4 * i);
            checks++; if (inst_pc !== exp_pc) begin errors++; $display("FAIL fault_pc[%0d] got %h expected %h", i, inst_pc, exp_pc); end
            checks++; if (inst_fault !== (i == 4)) begin errors++; $display("FAIL fault_flag[%0d] got %b expected %b", i, inst_fault, i == 4); end
            checks++;
            if (inst_data !== ((i == 4) ? 32'h0 : ROM_BASE + (exp_pc >> 2))) begin
                errors++;
                $display("FAIL fault_data[%0d] got %h expected %h", i, inst_data, (i == 4) ? 32'h0 : ROM_BASE + (exp_pc >> 2));
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b0)  begin errors++; $display("FAIL halted_valid[%0d] got %b expected 0", i, inst_valid); end
            checks++; if (imem_addr !== 32'd64) begin errors++; $display("FAIL halted_imem_addr[%0d] got %h expected 40", i, imem_addr); end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL fault_resume got valid=%b pc=%h expected valid=1 pc=0", inst_valid, inst_pc); end
    endtask

    task automatic test_fetch_en_drop();
        apply_reset();
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        repeat (4) tick();
        fetch_en   = 1'b0;
        inst_ready = 1'b1;
        tick();
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL drop_count got %0d expected 2", fifo_count); end
        checks++; if (inst_pc !== 32'd4)   begin errors++; $display("FAIL drop_head_pc got %h expected 4", inst_pc); end
        tick();
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got %b expected 0", inst_valid); end
        checks++; if (imem_addr !== 32'd3) begin errors++; $display("FAIL drained_imem_addr got %h expected 3", imem_addr); end
        fetch_en = 1'b1;
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rearm_valid got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_pc !== 32'd12)              begin errors++; $display("FAIL resume_pc got %h expected c", inst_pc); end
        checks++; if (inst_data !== ROM_BASE + 32'd3)  begin errors++; $display("FAIL resume_data got %h expected %h", inst_data, ROM_BASE + 32'd3); end
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b0;
        repeat (2) tick();
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d expected 3", fifo_count); end
        reset_n = 1'b0;
        tick();
        checks++;
        if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got valid=%b data=%h pc=%h fault=%b count=%0d expected all 0",
                     inst_valid, inst_data, inst_pc, inst_fault, fifo_count);
        end
        checks++; if (imem_addr !== (RESET_PC >> 2)) begin errors++; $display("FAIL mid_reset_imem_addr got %h expected %h", imem_addr, RESET_PC >> 2); end
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        tick();
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin errors++; $display("FAIL mid_restart got valid=%b pc=%h expected valid=1 pc=%h", inst_valid, inst_pc, RESET_PC); end
    endtask

    task automatic test_random();
        logic [31:0] e_pc, e_data;
        logic        e_valid, e_fault;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            reset_n        = ($urandom_range(0, 99) != 0);
            fetch_en       = ($urandom_range(0, 7) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom_range(0, ROM_SIZE * 4 + 40);
            tick();
            e_valid = (mq.size() != 0);
            e_pc    = e_valid ? mq[0].pc    : 32'h0;
            e_data  = e_valid ? mq[0].data  : 32'h0;
            e_fault = e_valid ? mq[0].fault : 1'b0;
            checks++; if (inst_valid !== e_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b expected %b", i, inst_valid, e_valid); end
            checks++; if (inst_pc !== e_pc)       begin errors++; $display("FAIL rnd_pc[%0d] got %h expected %h", i, inst_pc, e_pc); end
            checks++; if (inst_data !== e_data)   begin errors++; $display("FAIL rnd_data[%0d] got %h expected %h", i, inst_data, e_data); end
            checks++; if (inst_fault !== e_fault) begin errors++; $display("FAIL rnd_fault[%0d] got %b expected %b", i, inst_fault, e_fault); end
            checks++; if (32'(fifo_count) !== mq.size()) begin errors++; $display("FAIL rnd_count[%0d] got %0d expected %0d", i, fifo_count, mq.size()); end
            checks++; if (imem_addr !== (m_pc >> 2)) begin errors++; $display("FAIL rnd_imem_addr[%0d] got %h expected %h", i, imem_addr, m_pc >> 2); end
        end
        reset_n        = 1'b1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        m_pc           = RESET_PC;
        m_mode         = M_IDLE;
        test_reset();
        test_startup_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_fetch_en_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
